// File: rtl/stream_downsample.sv
// -----------------------------------------------------------------------------
// stream_downsample
//
// Valid/ready decimator for raster-ordered pixel streams. Keeps one pixel per
// FACTOR_X columns and one row per FACTOR_Y rows of an IMG_W x IMG_H frame and
// drops the rest. Kept pixels pass through a one-entry registered output stage
// that also carries an end-of-frame marker. A per-frame bypass mode, latched on
// the first beat of each frame, forwards every pixel.
//
// Ports:
//   CLK             clock, all state updates on the rising edge
//   RESET           synchronous, active-high reset
//   bypass          1 = forward every pixel, 0 = decimate (sampled at frame start)
//   data_in_valid   input pixel present
//   data_in_data    input pixel
//   data_in_ready   block accepts the input pixel this cycle
//   data_out_valid  output register holds a pixel
//   data_out_data   output pixel
//   data_out_last   output pixel is the last kept pixel of its frame
//   data_out_ready  downstream accepts the output pixel
// -----------------------------------------------------------------------------
module stream_downsample #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int FACTOR_X   = 2,
    parameter int FACTOR_Y   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  bypass,
    input  logic                  data_in_valid,
    input  logic [DATA_WIDTH-1:0] data_in_data,
    output logic                  data_in_ready,
    output logic                  data_out_valid,
    output logic [DATA_WIDTH-1:0] data_out_data,
    output logic                  data_out_last,
    input  logic                  data_out_ready
);

    localparam int XW  = (IMG_W    > 1) ? $clog2(IMG_W)    : 1;
    localparam int YW  = (IMG_H    > 1) ? $clog2(IMG_H)    : 1;
    localparam int PXW = (FACTOR_X > 1) ? $clog2(FACTOR_X) : 1;
    localparam int PYW = (FACTOR_Y > 1) ? $clog2(FACTOR_Y) : 1;

    localparam logic [XW-1:0]  X_MAX  = XW'(IMG_W - 1);
    localparam logic [YW-1:0]  Y_MAX  = YW'(IMG_H - 1);
    localparam logic [PXW-1:0] PX_MAX = PXW'(FACTOR_X - 1);
    localparam logic [PYW-1:0] PY_MAX = PYW'(FACTOR_Y - 1);

    // Coordinates of the last kept pixel of a decimated frame: the largest
    // multiple of the factor that still lies inside the frame.
    localparam logic [XW-1:0]  X_LAST_DEC = XW'(((IMG_W - 1) / FACTOR_X) * FACTOR_X);
    localparam logic [YW-1:0]  Y_LAST_DEC = YW'(((IMG_H - 1) / FACTOR_Y) * FACTOR_Y);

    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [PXW-1:0]        px_q, px_d;
    logic [PYW-1:0]        py_q, py_d;
    logic                  mode_q, mode_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;

    logic                  frame_start_s;
    logic                  mode_s;
    logic                  keep_s;
    logic                  last_s;
    logic                  x_end_s;
    logic                  y_end_s;
    logic                  in_ready_s;
    logic                  accept_s;

    // Decode of the current beat: mode, keep/last decision and handshake.
    always_comb begin
        frame_start_s = (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
        // At the first beat of a frame the live bypass input decides the mode;
        // everywhere else the mode latched at that beat is used.
        mode_s  = frame_start_s ? bypass : mode_q;
        keep_s  = mode_s | ((px_q == {PXW{1'b0}}) & (py_q == {PYW{1'b0}}));
        x_end_s = (x_q == X_MAX);
        y_end_s = (y_q == Y_MAX);
        if (mode_s) begin
            last_s = x_end_s & y_end_s;
        end else begin
            last_s = (x_q == X_LAST_DEC) & (y_q == Y_LAST_DEC);
        end
        // Dropped pixels never need the output register, so they are taken
        // even while the output is stalled.
        in_ready_s = ~RESET & (~keep_s | ~out_valid_q | data_out_ready);
        accept_s   = data_in_valid & in_ready_s;
    end

    // Next-state of the raster counters, phase counters and frame mode.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        px_d   = px_q;
        py_d   = py_q;
        mode_d = mode_q;
        if (accept_s) begin
            if (frame_start_s) begin
                mode_d = bypass;
            end else begin
                mode_d = mode_q;
            end
            if (x_end_s) begin
                x_d  = {XW{1'b0}};
                px_d = {PXW{1'b0}};
                if (y_end_s) begin
                    y_d  = {YW{1'b0}};
                    py_d = {PYW{1'b0}};
                end else begin
                    y_d = y_q + YW'(1'b1);
                    if (py_q == PY_MAX) begin
                        py_d = {PYW{1'b0}};
                    end else begin
                        py_d = py_q + PYW'(1'b1);
                    end
                end
            end else begin
                x_d = x_q + XW'(1'b1);
                if (px_q == PX_MAX) begin
                    px_d = {PXW{1'b0}};
                end else begin
                    px_d = px_q + PXW'(1'b1);
                end
            end
        end else begin
            x_d  = x_q;
            px_d = px_q;
        end
    end

    // Next-state of the one-entry output register; a load wins over a drain
    // so a simultaneous drain and load keeps full throughput.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (accept_s && keep_s) begin
            out_valid_d = 1'b1;
            out_data_d  = data_in_data;
            out_last_d  = last_s;
        end else if (out_valid_q && data_out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_q         <= {XW{1'b0}};
            y_q         <= {YW{1'b0}};
            px_q        <= {PXW{1'b0}};
            py_q        <= {PYW{1'b0}};
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            px_q        <= px_d;
            py_q        <= py_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign data_in_ready  = in_ready_s;
    assign data_out_valid = out_valid_q;
    assign data_out_data  = out_data_q;
    assign data_out_last  = out_last_q;

endmodule
